// File: rtl/mac_pkg.sv
// Shared constants, FSM state type and output saturation for the streaming MAC.
package mac_pkg;

  localparam int DATA_W = 16;
  localparam int Q_FRAC = 8;
  localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [1:0] {
    FILL,
    DRAIN,
    OUT
  } state_t;

  // Clamp a sign-extended accumulator value into the signed Q8.8 output range.
  function automatic logic [DATA_W-1:0] sat16(input logic signed [31:0] x);
    if (x > 32'sd32767) begin
      return SAT_MAX;
    end else if (x < -32'sd32768) begin
      return SAT_MIN;
    end else begin
      return DATA_W'(x);
    end
  endfunction

endpackage

// File: rtl/mac_stream_seq_if.sv
// Pair input stream and result output stream of the MAC; master drives pairs, slave is the engine.
interface mac_stream_seq_if;
  import mac_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic signed [DATA_W-1:0] in_weight;
  logic signed [DATA_W-1:0] bias;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_res;

  modport master (
    output in_valid, in_data, in_weight, bias, out_ready,
    input  in_ready, out_valid, out_res
  );

  modport slave (
    input  in_valid, in_data, in_weight, bias, out_ready,
    output in_ready, out_valid, out_res
  );

endinterface

// File: rtl/mult.sv
// Signed Q8.8 multiplier: full product shifted back by the fraction width, truncated to 16 bits.
module mult
  import mac_pkg::*;
(
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] p_o
);

  logic signed [2*DATA_W-1:0] full;

  assign full = a_i * b_i;
  assign p_o  = DATA_W'(full >>> Q_FRAC);

endmodule

// File: rtl/mac_stream_seq.sv
// Streaming dot-product engine: packs (data, weight) pairs into triples, multiplies them
// three at a time and accumulates one LEN-long vector plus bias into a saturated Q8.8 result.
module mac_stream_seq
  import mac_pkg::*;
#(
  parameter int LEN   = 48,
  parameter int ACC_W = 24
) (
  input logic             clk,
  input logic             rst,
  mac_stream_seq_if.slave bus
);

  localparam int               CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(LEN - 1);

  state_t                   state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [1:0]               idx_q;
  logic [1:0]               drain_q;
  logic signed [DATA_W-1:0] slot_a_q [2];
  logic signed [DATA_W-1:0] slot_b_q [2];
  logic signed [DATA_W-1:0] stage_a_q [3];
  logic signed [DATA_W-1:0] stage_b_q [3];
  logic signed [DATA_W-1:0] prod [3];
  logic signed [ACC_W-1:0]  sum_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [DATA_W-1:0] out_res_q;

  logic                     accept;
  logic                     last_pair;
  logic                     grp_done;
  logic signed [DATA_W-1:0] grp_a [3];
  logic signed [DATA_W-1:0] grp_b [3];

  assign accept    = bus.in_valid && (state_q == FILL);
  assign last_pair = (cnt_q == LAST);
  assign grp_done  = accept && ((idx_q == 2'd2) || last_pair);

  // Triple = stored slots below idx, the incoming pair at idx, zeros above (partial last group).
  always_comb begin
    grp_a[0] = (idx_q == 2'd0) ? bus.in_data   : slot_a_q[0];
    grp_b[0] = (idx_q == 2'd0) ? bus.in_weight : slot_b_q[0];
    grp_a[1] = '0;
    grp_b[1] = '0;
    if (idx_q == 2'd1) begin
      grp_a[1] = bus.in_data;
      grp_b[1] = bus.in_weight;
    end else if (idx_q == 2'd2) begin
      grp_a[1] = slot_a_q[1];
      grp_b[1] = slot_b_q[1];
    end
    grp_a[2] = (idx_q == 2'd2) ? bus.in_data   : '0;
    grp_b[2] = (idx_q == 2'd2) ? bus.in_weight : '0;
  end

  for (genvar g = 0; g < 3; g++) begin : g_mult
    mult u_mult (
      .a_i (stage_a_q[g]),
      .b_i (stage_b_q[g]),
      .p_o (prod[g])
    );
  end

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      idx_q     <= '0;
      drain_q   <= '0;
      // NOTE: the small slot/stage arrays are reset too so a discarded partial vector leaves nothing behind.
      for (int k = 0; k < 2; k++) begin
        slot_a_q[k] <= '0;
        slot_b_q[k] <= '0;
      end
      for (int k = 0; k < 3; k++) begin
        stage_a_q[k] <= '0;
        stage_b_q[k] <= '0;
      end
      sum_q     <= '0;
      acc_q     <= '0;
      out_res_q <= '0;
    end else begin
      // Idle cycles load zeros into the stage, so acc can add sum_q unconditionally.
      for (int k = 0; k < 3; k++) begin
        stage_a_q[k] <= grp_done ? grp_a[k] : '0;
        stage_b_q[k] <= grp_done ? grp_b[k] : '0;
      end
      sum_q <= ACC_W'(prod[0]) + ACC_W'(prod[1]) + ACC_W'(prod[2]);
      acc_q <= (accept && (cnt_q == '0)) ? ACC_W'(bus.bias) : acc_q + sum_q;

      case (state_q)
        FILL: begin
          if (accept) begin
            if (!grp_done) begin
              slot_a_q[idx_q[0]] <= bus.in_data;
              slot_b_q[idx_q[0]] <= bus.in_weight;
            end
            idx_q <= grp_done ? 2'd0 : idx_q + 2'd1;
            if (last_pair) begin
              cnt_q   <= '0;
              state_q <= DRAIN;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_q == 2'd2) begin
            drain_q   <= '0;
            out_res_q <= sat16(32'(acc_q));
            state_q   <= OUT;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            state_q <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == FILL);
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_res   = out_res_q;

endmodule

// File: tb/tb_mac_stream_seq.sv
// Scoreboard bench for mac_stream_seq: three instances (LEN 3, 4, 6) share one driver selected by sel.
module tb_mac_stream_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        drv_valid = 1'b0;
  logic [15:0] drv_data = '0;
  logic [15:0] drv_weight = '0;
  logic [15:0] drv_bias = '0;
  logic        drv_ready = 1'b0;
  int          sel = 0;

  logic        mon_in_ready;
  logic        mon_out_valid;
  logic [15:0] mon_out_res;

  int          n_vec = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];
  logic [15:0] pd[64];
  logic [15:0] pw[64];

  always #5 clk = ~clk;

  mac_stream_seq_if if3 ();
  mac_stream_seq_if if4 ();
  mac_stream_seq_if if6 ();

  assign if3.in_valid = drv_valid && (sel == 0);
  assign if4.in_valid = drv_valid && (sel == 1);
  assign if6.in_valid = drv_valid && (sel == 2);
  assign if3.out_ready = drv_ready && (sel == 0);
  assign if4.out_ready = drv_ready && (sel == 1);
  assign if6.out_ready = drv_ready && (sel == 2);
  assign if3.in_data = drv_data;   assign if3.in_weight = drv_weight; assign if3.bias = drv_bias;
  assign if4.in_data = drv_data;   assign if4.in_weight = drv_weight; assign if4.bias = drv_bias;
  assign if6.in_data = drv_data;   assign if6.in_weight = drv_weight; assign if6.bias = drv_bias;

  mac_stream_seq #(.LEN(3), .ACC_W(24)) dut3 (.clk(clk), .rst(rst), .bus(if3));
  mac_stream_seq #(.LEN(4), .ACC_W(24)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  mac_stream_seq #(.LEN(6), .ACC_W(24)) dut6 (.clk(clk), .rst(rst), .bus(if6));

  always_comb begin
    case (sel)
      0: begin mon_in_ready = if3.in_ready; mon_out_valid = if3.out_valid; mon_out_res = if3.out_res; end
      1: begin mon_in_ready = if4.in_ready; mon_out_valid = if4.out_valid; mon_out_res = if4.out_res; end
      default: begin mon_in_ready = if6.in_ready; mon_out_valid = if6.out_valid; mon_out_res = if6.out_res; end
    endcase
  end

  task automatic send_pair(input logic [15:0] d, input logic [15:0] w);
    int n = 0;
    @(negedge clk);
    drv_valid = 1'b1; drv_data = d; drv_weight = w;
    while (!mon_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!mon_in_ready) begin
      n_vec++; n_fail++;
      $display("FAIL send_pair: in_ready stayed low for %0d cycles", n);
    end
    @(posedge clk);
    #1 drv_valid = 1'b0;
  endtask

  task automatic send_vec(input int len, input logic [15:0] b, input bit gap);
    drv_bias = b;
    for (int i = 0; i < len; i++) begin
      send_pair(pd[i], pw[i]);
      if (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic push_model(input int len, input logic [15:0] b);
    int acc;
    logic signed [31:0] p;
    logic signed [15:0] q;
    acc = int'($signed(b));
    for (int i = 0; i < len; i++) begin
      p = $signed(pd[i]) * $signed(pw[i]);
      q = p[23:8];
      acc += int'(q);
    end
    if (acc > 32767) exp_q.push_back(16'h7FFF);
    else if (acc < -32768) exp_q.push_back(16'h8000);
    else exp_q.push_back(acc[15:0]);
  endtask

  task automatic collect(input string name);
    int n = 0;
    logic [15:0] e;
    while (!mon_out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (!mon_out_valid) begin
      n_fail++;
      $display("FAIL %s: out_valid never rose (waited %0d cycles)", name, n);
      return;
    end
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: result 0x%04h with nothing expected", name, mon_out_res);
    end else begin
      e = exp_q.pop_front();
      if (mon_out_res !== e) begin
        n_fail++;
        $display("FAIL %s: out_res got 0x%04h want 0x%04h", name, mon_out_res, e);
      end
    end
    drv_ready = 1'b1;
    @(posedge clk);
    #1 drv_ready = 1'b0;
  endtask

  task automatic load_test1_pairs();
    pd[0] = 16'h0100; pw[0] = 16'h0200;
    pd[1] = 16'h0080; pw[1] = 16'h0400;
    pd[2] = 16'hFF00; pw[2] = 16'h0100;
    pd[3] = 16'h0100; pw[3] = 16'h0100;
  endtask

  task automatic check_idle(input string name);
    n_vec++;
    if (mon_out_valid !== 1'b0 || mon_out_res !== 16'h0000 || mon_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: out_valid=%b out_res=0x%04h in_ready=%b want 0/0x0000/1",
               name, mon_out_valid, mon_out_res, mon_in_ready);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1 check_idle($sformatf("reset_state_len_sel%0d", s));
    end
    sel = 0;
  endtask

  task automatic test_basic_latency();
    sel = 0;
    load_test1_pairs();
    exp_q.push_back(16'h0300);
    send_vec(3, 16'h0000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++;
      if (mon_out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL latency_early_%0d: out_valid got %b want 0", k, mon_out_valid);
      end
    end
    @(negedge clk);
    n_vec++;
    if (mon_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_edge3: out_valid got %b want 1", mon_out_valid);
    end
    collect("basic_len3");
  endtask

  task automatic test_partial_group();
    sel = 1;
    load_test1_pairs();
    exp_q.push_back(16'h0400);
    send_vec(4, 16'h0000, 1'b0);
    collect("partial_len4");
  endtask

  task automatic test_saturation();
    sel = 2;
    for (int i = 0; i < 6; i++) begin pd[i] = 16'h7F00; pw[i] = 16'h0100; end
    exp_q.push_back(16'h7FFF);
    send_vec(6, 16'h0000, 1'b0);
    collect("sat_pos");
    for (int i = 0; i < 6; i++) begin pd[i] = 16'h8100; pw[i] = 16'h0100; end
    exp_q.push_back(16'h8000);
    send_vec(6, 16'h0000, 1'b0);
    collect("sat_neg");
  endtask

  task automatic test_backpressure();
    logic [15:0] e;
    int n = 0;
    sel = 0;
    load_test1_pairs();
    exp_q.push_back(16'h0300);
    send_vec(3, 16'h0000, 1'b0);
    while (!mon_out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    for (int k = 0; k < 5; k++) begin
      drv_valid = 1'b1; drv_data = 16'h1234; drv_weight = 16'h0400;
      @(negedge clk);
      n_vec++;
      if (mon_out_valid !== 1'b1 || mon_out_res !== e || mon_in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_%0d: out_valid=%b out_res=0x%04h in_ready=%b want 1/0x%04h/0",
                 k, mon_out_valid, mon_out_res, mon_in_ready, e);
      end
    end
    drv_valid = 1'b0;
    drv_ready = 1'b1;
    @(posedge clk);
    #1 drv_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (mon_in_ready !== 1'b1 || mon_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL release: in_ready=%b out_valid=%b want 1/0", mon_in_ready, mon_out_valid);
    end
    exp_q.push_back(16'h0300);
    send_vec(3, 16'h0000, 1'b0);
    collect("after_hold");
  endtask

  task automatic test_bias_and_gaps();
    sel = 0;
    for (int i = 0; i < 3; i++) begin pd[i] = 16'h0000; pw[i] = 16'h0000; end
    exp_q.push_back(16'h0080);
    send_vec(3, 16'h0080, 1'b0);
    collect("bias_only");
    exp_q.push_back(16'h0080);
    send_vec(3, 16'h0080, 1'b1);
    collect("bias_gapped");
  endtask

  task automatic test_mid_reset();
    sel = 0;
    load_test1_pairs();
    pw[0] = 16'h0700;
    send_vec(2, 16'h0300, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 check_idle("mid_reset_outputs");
    load_test1_pairs();
    exp_q.push_back(16'h0300);
    send_vec(3, 16'h0000, 1'b0);
    collect("after_reset");
  endtask

  task automatic test_back_to_back_random();
    sel = 2;
    for (int v = 0; v < 4; v++) begin
      logic [15:0] b;
      b = 16'($urandom);
      for (int i = 0; i < 6; i++) begin
        pd[i] = 16'($urandom);
        pw[i] = 16'($urandom);
      end
      push_model(6, b);
      send_vec(6, b, v[0]);
      collect($sformatf("random_vec%0d", v));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_basic_latency();
    test_partial_group();
    test_saturation();
    test_backpressure();
    test_bias_and_gaps();
    test_mid_reset();
    test_back_to_back_random();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d results still expected, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
